// File: rtl/branch_unit_pkg.sv
// Shared constants, ALU op codes and the output bundle for the RV32I branch unit.
package branch_unit_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_SELECT_LEN = 5;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;

    typedef struct packed {
        logic [REG_SELECT_LEN-1:0] register_1;
        logic [REG_SELECT_LEN-1:0] register_2;
        logic [XLEN-1:0]           alu_a;
        logic [XLEN-1:0]           alu_b;
        logic [2:0]                alu_op;
        logic                      load_new_pc;
        logic [XLEN-1:0]           new_pc;
    } branch_output_t;

endpackage

// File: rtl/branch_imm_gen.sv
// Sign-extended B, J and I immediates from the upper instruction bits.
module branch_imm_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr_hi,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_j,
    output logic [XLEN-1:0] imm_i
);

    assign imm_b = {{(XLEN-12){instr_hi[31]}}, instr_hi[7], instr_hi[30:25], instr_hi[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){instr_hi[31]}}, instr_hi[19:12], instr_hi[20], instr_hi[30:21], 1'b0};
    assign imm_i = {{(XLEN-11){instr_hi[31]}}, instr_hi[30:20]};

endmodule

// File: rtl/branch_unit.sv
// RV32I branch/jump unit: drives register selects and shared-ALU operands
// combinationally, resolves the target and presents the PC load one cycle later.
module branch_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_SELECT_LEN = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_n,
    input  logic [XLEN-1:0]           instruction,
    input  logic [XLEN-1:0]           program_counter,
    input  logic [XLEN-1:0]           register_data_1,
    input  logic [XLEN-1:0]           register_data_2,
    input  logic [XLEN-1:0]           alu_out,
    output logic [REG_SELECT_LEN-1:0] register_1,
    output logic [REG_SELECT_LEN-1:0] register_2,
    output logic [XLEN-1:0]           alu_a,
    output logic [XLEN-1:0]           alu_b,
    output logic [2:0]                alu_op,
    output logic                      load_new_pc,
    output logic [XLEN-1:0]           new_pc
);

    import branch_unit_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_i;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            active_c;
    logic            taken_c;
    logic [XLEN-1:0] target_c;
    logic            drive_rs1;
    logic            drive_rs2;
    branch_output_t  out_c;

    logic            valid_q;
    logic            taken_q;
    logic [XLEN-1:0] target_q;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];

    branch_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_hi (instruction[31:7]),
        .imm_b    (imm_b),
        .imm_j    (imm_j),
        .imm_i    (imm_i)
    );

    // Control-instruction classification; funct3 010/011 are not branches.
    always_comb begin
        is_branch = (opcode == OPC_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
        is_jal    = (opcode == OPC_JAL);
        is_jalr   = (opcode == OPC_JALR) && (funct3 == F3_JALR);
        active_c  = !enable_n && (is_branch || is_jal || is_jalr);
        drive_rs1 = active_c && !is_jal;
        drive_rs2 = active_c && is_branch;
    end

    // Operand selection, branch condition and target resolution.
    always_comb begin
        out_c             = '0;
        taken_c           = 1'b0;
        target_c          = '0;
        out_c.register_1  = instruction[19:15];
        out_c.register_2  = instruction[24:20];
        out_c.alu_a       = register_data_1;
        out_c.alu_b       = register_data_2;
        out_c.alu_op      = ALU_SUB;
        out_c.load_new_pc = taken_q;
        out_c.new_pc      = target_q;
        if (is_branch) begin
            case (funct3)
                F3_BEQ:          taken_c = (alu_out == '0);
                F3_BNE:          taken_c = (alu_out != '0);
                F3_BLT, F3_BLTU: taken_c = alu_out[0];
                default:         taken_c = !alu_out[0];
            endcase
            out_c.alu_op = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            target_c     = program_counter + imm_b;
        end else if (is_jal) begin
            taken_c  = 1'b1;
            target_c = program_counter + imm_j;
        end else if (is_jalr) begin
            out_c.alu_b  = imm_i;
            out_c.alu_op = ALU_ADD;
            taken_c      = 1'b1;
            target_c     = {alu_out[XLEN-1:1], 1'b0};
        end
    end

    // Result register; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= active_c;
            taken_q  <= taken_c;
            target_q <= target_c;
        end
    end

    assign register_1  = drive_rs1 ? out_c.register_1 : 'z;
    assign register_2  = drive_rs2 ? out_c.register_2 : 'z;
    assign alu_a       = drive_rs1 ? out_c.alu_a      : 'z;
    assign alu_b       = drive_rs1 ? out_c.alu_b      : 'z;
    assign alu_op      = drive_rs1 ? out_c.alu_op     : 'z;
    assign load_new_pc = valid_q   ? out_c.load_new_pc : 1'bz;
    assign new_pc      = valid_q   ? out_c.new_pc     : 'z;

endmodule

// File: tb/tb_branch_unit.sv
// Randomized self-checking bench for branch_unit. Two instances share the inputs,
// one on pull-down nets and one on pull-up nets, so a released output is seen as 0 / all-ones.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_n;
    logic [31:0] instruction;
    logic [31:0] program_counter;
    logic [31:0] register_data_1;
    logic [31:0] register_data_2;
    logic [31:0] alu_out;

    tri0 [4:0]  r1_lo, r2_lo;
    tri0 [31:0] a_lo, b_lo, npc_lo;
    tri0 [2:0]  op_lo;
    tri0        lnp_lo;
    tri1 [4:0]  r1_hi, r2_hi;
    tri1 [31:0] a_hi, b_hi, npc_hi;
    tri1 [2:0]  op_hi;
    tri1        lnp_hi;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (what the unit should have registered).
    bit          m_valid;
    bit          m_taken;
    logic [31:0] m_target;

    always #5 clk = ~clk;

    branch_unit u_dut_lo (
        .clk(clk), .reset(reset), .enable_n(enable_n), .instruction(instruction),
        .program_counter(program_counter), .register_data_1(register_data_1),
        .register_data_2(register_data_2), .alu_out(alu_out),
        .register_1(r1_lo), .register_2(r2_lo), .alu_a(a_lo), .alu_b(b_lo),
        .alu_op(op_lo), .load_new_pc(lnp_lo), .new_pc(npc_lo)
    );

    branch_unit u_dut_hi (
        .clk(clk), .reset(reset), .enable_n(enable_n), .instruction(instruction),
        .program_counter(program_counter), .register_data_1(register_data_1),
        .register_data_2(register_data_2), .alu_out(alu_out),
        .register_1(r1_hi), .register_2(r2_hi), .alu_a(a_hi), .alu_b(b_hi),
        .alu_op(op_hi), .load_new_pc(lnp_hi), .new_pc(npc_hi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A driven output reads the same on both nets; a released one reads 0 / all-ones.
    task automatic check_out(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                             input bit drive, input logic [31:0] val, input logic [31:0] ones);
        check({tag, "_lo"}, lo, drive ? val : 32'h0);
        check({tag, "_hi"}, hi, drive ? val : ones);
    endtask

    // Behavioural model computed from the instruction-set rules with integer arithmetic.
    task automatic model(output bit act, output bit d_r1, output bit d_r2,
                         output logic [31:0] e_r1, output logic [31:0] e_r2,
                         output logic [31:0] e_a, output logic [31:0] e_b,
                         output logic [31:0] e_op, output bit tk, output logic [31:0] tgt);
        int unsigned ins, op, f3;
        int b_imm, j_imm, i_imm;
        bit br, jal, jalr;
        ins  = instruction;
        op   = ins & 32'h7f;
        f3   = (ins >> 12) & 7;
        br   = (op == 99) && (f3 != 2) && (f3 != 3);
        jal  = (op == 111);
        jalr = (op == 103) && (f3 == 0);
        act  = !enable_n && (br || jal || jalr);
        b_imm = int'((((ins >> 8) & 15) << 1) + (((ins >> 25) & 63) << 5) + (((ins >> 7) & 1) << 11));
        if (ins >= 32'h8000_0000) b_imm = b_imm - 4096;
        j_imm = int'((((ins >> 21) & 1023) << 1) + (((ins >> 20) & 1) << 11) + (((ins >> 12) & 255) << 12));
        if (ins >= 32'h8000_0000) j_imm = j_imm - 1048576;
        i_imm = int'((ins >> 20) & 2047);
        if (ins >= 32'h8000_0000) i_imm = i_imm - 2048;
        d_r1 = act && !jal;
        d_r2 = act && br;
        e_r1 = (ins >> 15) & 31;
        e_r2 = (ins >> 20) & 31;
        e_a  = register_data_1;
        e_b  = jalr ? 32'(i_imm) : register_data_2;
        e_op = jalr ? 0 : (f3 < 4) ? 1 : (f3 < 6) ? 2 : 3;
        tk   = 1'b1;
        tgt  = 32'h0;
        if (br) begin
            case (f3)
                0:       tk = (alu_out == 0);
                1:       tk = (alu_out != 0);
                4, 6:    tk = (alu_out % 2) == 1;
                default: tk = (alu_out % 2) == 0;
            endcase
            tgt = program_counter + 32'(b_imm);
        end else if (jal) begin
            tgt = program_counter + 32'(j_imm);
        end else if (jalr) begin
            tgt = alu_out - (alu_out % 2);
        end
    endtask

    // One cycle: apply inputs, check combinational outputs, clock, check registered outputs.
    task automatic cycle(input bit rst, input bit en_n, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] ao);
        bit act, d_r1, d_r2, tk;
        logic [31:0] e_r1, e_r2, e_a, e_b, e_op, tgt;
        reset = rst; enable_n = en_n; instruction = ins; program_counter = pc;
        register_data_1 = d1; register_data_2 = d2; alu_out = ao;
        #2;
        model(act, d_r1, d_r2, e_r1, e_r2, e_a, e_b, e_op, tk, tgt);
        check_out("register_1", 32'(r1_lo), 32'(r1_hi), d_r1, e_r1, 32'h1f);
        check_out("register_2", 32'(r2_lo), 32'(r2_hi), d_r2, e_r2, 32'h1f);
        check_out("alu_a", a_lo, a_hi, d_r1, e_a, 32'hffff_ffff);
        check_out("alu_b", b_lo, b_hi, d_r1, e_b, 32'hffff_ffff);
        check_out("alu_op", 32'(op_lo), 32'(op_hi), d_r1, e_op, 32'h7);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_taken = 1'b0; m_target = 32'h0;
        end else begin
            m_valid = act; m_taken = tk; m_target = tgt;
        end
        #1;
        check_out("load_new_pc", 32'(lnp_lo), 32'(lnp_hi), m_valid, 32'(m_taken), 32'h1);
        check_out("new_pc", npc_lo, npc_hi, m_valid, m_target, 32'hffff_ffff);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 5)       w = {w[31:7], 7'b1100011};
        else if (k == 5) w = {w[31:7], 7'b1101111};
        else if (k < 8)  w = {w[31:15], ($urandom_range(0, 3) == 0) ? w[14:12] : 3'b000, w[11:7], 7'b1100111};
        return w;
    endfunction

    initial begin
        logic [31:0] ao;
        reset = 1'b1; enable_n = 1'b1; instruction = '0; program_counter = '0;
        register_data_1 = '0; register_data_2 = '0; alu_out = '0;
        m_valid = 1'b0; m_taken = 1'b0; m_target = '0;
        @(posedge clk); #1;
        cycle(1, 0, 32'h0020_8463, 32'h100, 32'd5, 32'd5, 32'd0);
        // Directed cases from the reference vectors.
        cycle(0, 0, 32'h0020_8463, 32'h0000_0100, 32'd5, 32'd5, 32'd0);
        cycle(0, 0, 32'h0020_9463, 32'hffff_fffc, 32'd7, 32'd7, 32'd0);
        cycle(0, 0, 32'hffdf_f06f, 32'h0000_0200, 32'd1, 32'd2, 32'd3);
        cycle(0, 0, 32'h0042_8067, 32'h0000_0300, 32'h1001, 32'd9, 32'h1005);
        cycle(0, 1, 32'h0020_8463, 32'h0000_0100, 32'd5, 32'd5, 32'd0);
        cycle(0, 0, 32'h0000_0013, 32'h0000_0100, 32'd5, 32'd5, 32'd0);
        cycle(0, 0, 32'h0020_a463, 32'h0000_0100, 32'd5, 32'd5, 32'd0);
        cycle(0, 0, 32'h0020_8463, 32'h0000_0100, 32'd5, 32'd5, 32'd0);
        cycle(1, 0, 32'h0020_8463, 32'h0000_0100, 32'd5, 32'd5, 32'd0);
        cycle(0, 1, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            ao = $urandom;
            if ($urandom_range(0, 3) == 0) ao = 32'h0;
            else if ($urandom_range(0, 1) == 0) ao = 32'($urandom_range(0, 1));
            cycle($urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0, rand_instr(),
                  $urandom, $urandom, $urandom, ao);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
